// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the four-digit BCD counter.
package bcd_counter_pkg;

   typedef enum logic {STOP = 1'b0, RUN = 1'b1} cnt_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Button lanes, in the order they are packed into the debouncer array
   localparam int NUM_BTN      = 3;
   localparam int BTN_RUN_IDX  = 0;
   localparam int BTN_CLR_IDX  = 1;
   localparam int BTN_LOAD_IDX = 2;

   // Clamp a nibble to a legal BCD digit
   function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to one-cycle press pulse: 2-FF synchroniser, stability
// counter, rising-edge detect on the debounced level.
module btn_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic gclk,
   input  logic grst_n,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1, sync2;
   logic          level, level_d;
   logic [CW-1:0] stab_cnt;

   // Two-flop synchroniser for the asynchronous button input
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Accept a new level after DEB_CYCLES consecutive differing samples;
   // any sample matching the current level restarts the count
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         level    <= 1'b0;
         stab_cnt <= '0;
      end else if (sync2 != level) begin
         if (stab_cnt == CW'(DEB_CYCLES - 1)) begin
            level    <= sync2;
            stab_cnt <= '0;
         end else begin
            stab_cnt <= stab_cnt + CW'(1);
         end
      end else begin
         stab_cnt <= '0;
      end
   end

   // Delayed level for rising-edge detection
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) level_d <= 1'b0;
      else         level_d <= level;
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with run/stop, clear and load buttons.
// count[15:0] carries one BCD digit per nibble, digit 0 in bits [3:0].
module bcd_counter4
   import bcd_counter_pkg::*;
#(
   parameter int TICK_DIV   = 10_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        BTN_RUN,
   input  logic        BTN_CLR,
   input  logic        BTN_LOAD,
   input  logic        up_dn,
   input  logic [15:0] load_val,
   output logic [15:0] count,
   output logic        running,
   output logic        wrap
);

   localparam int PW = $clog2(TICK_DIV);

   logic [NUM_BTN-1:0] btn_raw, btn_press;
   logic               run_p, clr_p, load_p;

   cnt_state_t            state, state_nxt;
   logic [PW-1:0]         presc, presc_nxt;
   bcd_digit_t [3:0]      digits, digits_nxt, step_val, load_sat;
   logic                  step_carry, wrap_nxt;

   assign btn_raw = {BTN_LOAD, BTN_CLR, BTN_RUN};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .gclk   (CLK100MHZ),
         .grst_n (CPU_RESETN),
         .btn    (btn_raw[i]),
         .press  (btn_press[i])
      );
   end

   assign run_p  = btn_press[BTN_RUN_IDX];
   assign clr_p  = btn_press[BTN_CLR_IDX];
   assign load_p = btn_press[BTN_LOAD_IDX];

   // One BCD step with per-digit ripple; step_carry set means all four
   // digits rolled over
   always_comb begin
      step_val   = digits;
      step_carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (step_carry) begin
            if (up_dn) begin
               if (digits[i] >= BCD_MAX) begin
                  step_val[i] = '0;
               end else begin
                  step_val[i] = digits[i] + 4'd1;
                  step_carry  = 1'b0;
               end
            end else begin
               if (digits[i] == '0) begin
                  step_val[i] = BCD_MAX;
               end else begin
                  step_val[i] = digits[i] - 4'd1;
                  step_carry  = 1'b0;
               end
            end
         end
      end
   end

   // Load value with out-of-range nibbles clamped to 9
   always_comb begin
      load_sat = '0;
      for (int i = 0; i < 4; i++) load_sat[i] = bcd_sat(load_val[i*4 +: 4]);
   end

   // Control: clear > load (STOP only) > run toggle > prescaled step
   always_comb begin
      state_nxt  = state;
      presc_nxt  = presc;
      digits_nxt = digits;
      wrap_nxt   = 1'b0;
      if (clr_p) begin
         digits_nxt = '0;
         state_nxt  = STOP;
         presc_nxt  = '0;
      end else if (load_p && state == STOP) begin
         digits_nxt = load_sat;
      end else if (run_p) begin
         if (state == STOP) begin
            state_nxt = RUN;
            presc_nxt = '0;
         end else begin
            state_nxt = STOP;
         end
      end else if (state == RUN) begin
         if (presc == PW'(TICK_DIV - 1)) begin
            presc_nxt  = '0;
            digits_nxt = step_val;
            wrap_nxt   = step_carry;
         end else begin
            presc_nxt = presc + PW'(1);
         end
      end
   end

   // State, prescaler and output registers
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state   <= STOP;
         presc   <= '0;
         digits  <= '0;
         wrap    <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         presc   <= presc_nxt;
         digits  <= digits_nxt;
         wrap    <= wrap_nxt;
         running <= (state_nxt == RUN);
      end
   end

   assign count = digits;

endmodule

// File: tb/tb_bcd_counter4.sv
// Scoreboard bench: every expected count change is queued before the
// stimulus that causes it; a negedge monitor pops one entry per change.
`timescale 1ns/100ps
module tb_bcd_counter4;

   localparam int B_RUN = 0, B_CLR = 1, B_LOAD = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        btn_run = 1'b0, btn_clr = 1'b0, btn_load = 1'b0;
   logic        up_dn = 1'b1;
   logic [15:0] load_val = '0;
   logic [15:0] count;
   logic        running, wrap;

   typedef struct {
      logic [15:0] cnt;
      logic        wr;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0, errors = 0;
   int          mval = 0;
   logic [15:0] prev = '0;

   bcd_counter4 #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .BTN_RUN    (btn_run),
      .BTN_CLR    (btn_clr),
      .BTN_LOAD   (btn_load),
      .up_dn      (up_dn),
      .load_val   (load_val),
      .count      (count),
      .running    (running),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'(v / 1000);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   task automatic push_val(input logic [15:0] v, input logic w);
      exp_t e;
      e.cnt = v;
      e.wr  = w;
      sbq.push_back(e);
   endtask

   task automatic push_steps(input int n);
      for (int i = 0; i < n; i++) begin
         if (up_dn) begin
            mval = (mval + 1) % 10000;
            push_val(to_bcd(mval), mval == 0);
         end else begin
            mval = (mval + 9999) % 10000;
            push_val(to_bcd(mval), mval == 9999);
         end
      end
   endtask

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         B_RUN:   btn_run  = v;
         B_CLR:   btn_clr  = v;
         default: btn_load = v;
      endcase
   endtask

   // Press effect lands on the 6th edge; then release and let the level settle
   task automatic press(input int which);
      set_btn(which, 1'b1);
      tick(6);
      set_btn(which, 1'b0);
      tick(6);
   endtask

   task automatic do_load(input logic [15:0] lv, input int dec);
      load_val = lv;
      mval     = dec;
      push_val(to_bcd(dec), 1'b0);
      press(B_LOAD);
      chk("load_cnt", count, to_bcd(dec));
   endtask

   // Run for a cycles (running edge to stop-press start); steps at 4k < a+6
   task automatic run_span(input int a);
      push_steps((a + 5) / 4);
      press(B_RUN);
      tick(a - 6);
      press(B_RUN);
      chk("stop_run", running, 0);
      chk("stop_cnt", count, to_bcd(mval));
   endtask

   // Every count change must match the next queued expectation
   always @(negedge clk) begin
      if (!rst_n) begin
         prev = '0;
      end else begin
         if (count !== prev) begin
            if (sbq.size() == 0) begin
               chk("sb_extra", count, prev);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_cnt", {wrap, count}, {e.wr, e.cnt});
            end
         end else begin
            chk("wrap_idle", wrap, 0);
         end
         prev = count;
      end
   end

   initial begin
      // Reset asserted between edges takes effect immediately
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cnt", count, 16'h0000);
      chk("rst_run", running, 0);
      chk("rst_wrap", wrap, 0);
      tick(2);
      rst_n = 1'b1;
      tick(4);
      chk("idle_cnt", count, 16'h0000);
      chk("idle_run", running, 0);

      // Two-cycle glitch is rejected
      btn_run = 1'b1;
      tick(2);
      btn_run = 1'b0;
      tick(8);
      chk("glitch_run", running, 0);

      // Held press: running rises exactly 6 cycles after the hold starts
      btn_run = 1'b1;
      tick(5);
      chk("deb_early", running, 0);
      tick(1);
      chk("deb_edge", running, 1);
      btn_run = 1'b0;
      push_steps(3);
      tick(3);
      chk("step_early", count, 16'h0000);
      tick(1);
      chk("step1", count, 16'h0001);
      tick(4);
      chk("step2", count, 16'h0002);
      tick(4);
      chk("step3", count, 16'h0003);

      // Async reset mid-count, with the run button held through release
      tick(1);
      #2;
      rst_n   = 1'b0;
      btn_run = 1'b1;
      #1;
      chk("arst_cnt", count, 16'h0000);
      chk("arst_run", running, 0);
      chk("arst_wrap", wrap, 0);
      mval = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(5);
      chk("held_early", running, 0);
      tick(1);
      chk("held_edge", running, 1);
      btn_run = 1'b0;
      push_steps(3);
      tick(10);
      press(B_RUN);
      chk("held_stop", running, 0);
      chk("held_cnt", count, 16'h0003);

      // Up across digit carries
      do_load(16'h0998, 998);
      run_span(6);
      chk("carry_cnt", count, 16'h1000);

      // Wrap up: 9998 -> 9999 -> 0000
      do_load(16'h9998, 9998);
      run_span(6);
      chk("wrap_up", count, 16'h0000);

      // Wrap down: 0001 -> 0000 -> 9999
      do_load(16'h0001, 1);
      up_dn = 1'b0;
      run_span(6);
      chk("wrap_dn", count, 16'h9999);
      up_dn = 1'b1;

      // Load saturation in STOP
      do_load(16'h0A5F, 959);

      // Load in RUN is ignored while stepping continues
      push_steps(5);
      press(B_RUN);
      load_val = 16'h1234;
      press(B_LOAD);
      press(B_RUN);
      chk("lock_run", running, 0);
      chk("lock_cnt", count, 16'h0964);

      // Clear and run accepted together while running at 0042
      do_load(16'h0040, 40);
      push_steps(2);
      push_val(16'h0000, 1'b0);
      press(B_RUN);
      btn_clr = 1'b1;
      btn_run = 1'b1;
      tick(6);
      chk("clr_cnt", count, 16'h0000);
      chk("clr_run", running, 0);
      btn_clr = 1'b0;
      btn_run = 1'b0;
      mval = 0;
      tick(6);
      chk("clr_hold", count, 16'h0000);

      chk("sb_left", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_counter4.md
# bcd_counter4

Four-digit BCD up/down counter with run/stop, clear and load controls driven by raw push-buttons. It is the value source for the four-digit seven-segment multiplexer: `count[15:0]` connects directly to that block's 16-bit hex input, one BCD digit per nibble (digit 0 = `count[3:0]`). Button inputs are synchronised and debounced inside the block.

## Interface
- `TICK_DIV`, default 10_000_000: clock cycles per count step (10 Hz at 100 MHz); legal range ≥ 2.
- `DEB_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a button level (10 ms); legal range ≥ 1.
- `CLK100MHZ` in 1: system clock.
- `CPU_RESETN` in 1: **one clock; reset is asynchronous and active-low**.
- `BTN_RUN` in 1: raw button; each accepted press toggles run/stop.
- `BTN_CLR` in 1: raw button; an accepted press clears the count and stops.
- `BTN_LOAD` in 1: raw button; an accepted press loads `load_val` (honoured only when stopped).
- `up_dn` in 1: count direction; 1 = up, 0 = down. Sampled on each step.
- `load_val` in 16: four BCD digits to load.
- `count` out 16: current BCD value.
- `running` out 1: high in the RUN state.
- `wrap` out 1: single-cycle pulse on 9999→0000 (up) or 0000→9999 (down).

## Operation
- States: STOP and RUN. Reset enters STOP.
- Button path per input: 2-FF synchroniser, then a stability counter. The debounced level changes only after `DEB_CYCLES` consecutive equal synchronised samples that differ from the current level. A rising edge of the debounced level produces one-cycle `press` pulses `run_p`, `clr_p` and `load_p`.
- Priority when pulses coincide in one cycle: `clr_p` > `load_p` > `run_p` > step.
  - `clr_p`: count ← 0000, state ← STOP, prescaler ← 0.
  - `load_p` in STOP: count ← `load_val`, with any nibble > 9 saturated to 9. `load_p` in RUN is ignored and does not block `run_p`.
  - `run_p`: toggles the state. Entering RUN zeroes the prescaler.
- Prescaler: counts 0..`TICK_DIV`-1 only in RUN and holds its value in STOP. A step occurs in the cycle it equals `TICK_DIV`-1; it then returns to 0.
- Step arithmetic: per-digit BCD ripple. Up: a digit at 9 becomes 0 and carries. Down: a digit at 0 becomes 9 and borrows. Digits never hold values above 9.
- `wrap` is high for exactly the step cycle that rolls all four digits. It is never asserted on clear or load.
- Reset values: `count` = 16'h0000, `running` = 0, `wrap` = 0, prescaler = 0, debounced levels = 0, synchronisers = 0.
- Reset asserted mid-count or mid-debounce drops everything to reset values immediately. After release, a button that is already held must complete a full debounce, and only then generates its press.

## Timing
- All outputs are registered.
- A button held stable from cycle t is first visible in the synchroniser output at t+2. The debounced level changes at t+2+`DEB_CYCLES`, and the press pulse and its effect appear on the outputs one cycle after that.
- In RUN, `count` changes every `TICK_DIV` cycles. The first step lands `TICK_DIV` cycles after `running` rises.
- `wrap` is coincident with the cycle in which `count` shows the wrapped value.
- Button release needs no debounce action beyond level tracking; a press is recognised on the rising edge only.

## Structure
- Shared package `bcd_counter_pkg` holds:
  - state enum `cnt_state_t` {STOP, RUN};
  - `typedef logic [3:0] bcd_digit_t`;
  - constant `BCD_MAX` = 4'd9.
- One sub-module, `btn_debounce`, containing the synchroniser, stability counter and rising-edge pulse. It is parameterised by `DEB_CYCLES` and instantiated three times.
- The top level holds the FSM, the prescaler and the BCD datapath. Expected size is about 200 lines total.

## Test plan
Run all scenarios with `TICK_DIV`=4 and `DEB_CYCLES`=3.
- **Reset:** assert `CPU_RESETN`=0 asynchronously between edges -> `count`=0000, `running`=0 and `wrap`=0 immediately; they stay there after release while no button is pressed.
- **Debounce:** toggle `BTN_RUN` for 2 cycles, then release -> no state change. Hold it for ≥6 cycles -> `running` goes to 1 exactly 6 cycles after the hold starts.
- **Run, up:** from 0000 with `up_dn`=1 -> count reads 0001, 0002, … at 4-cycle spacing. From a load of 0998, the counter reaches 1000 after two steps.
- **Wrap, down:** load 0001, `up_dn`=0, run -> 0000, then 9999 with `wrap` high for one cycle. Load 9999, `up_dn`=1 -> 0000 with `wrap` pulsed.
- **Load saturation and lockout:** `load_val`=16'h0A5F in STOP -> `count`=0959. The same load in RUN -> `count` is unchanged and continues stepping.
- **Simultaneous presses:** `BTN_CLR` and `BTN_RUN` accepted in the same cycle while in RUN at 0042 -> `count`=0000 and `running`=0.
